// File: rtl/regfile_scoreboard_if.sv
// Decode-side bundle for regfile_scoreboard: source reads, issue request/verdict,
// writeback and squash inputs, and the pending/error status outputs.
// master = decode/pipeline driver, slave = register file + scoreboard.
interface regfile_scoreboard_if;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_used;
  logic        rs2_used;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        hazard;
  logic        issue_fire;
  logic [4:0]  wreg;
  logic [31:0] wdata;
  logic        wen;
  logic        kill_valid;
  logic [4:0]  kill_rd;
  logic        pending_any;
  logic        err;

  modport master (
    output rs1, rs2, rs1_used, rs2_used, issue_valid, issue_rd,
           wreg, wdata, wen, kill_valid, kill_rd,
    input  rdata1, rdata2, hazard, issue_fire, pending_any, err
  );

  modport slave (
    input  rs1, rs2, rs1_used, rs2_used, issue_valid, issue_rd,
           wreg, wdata, wen, kill_valid, kill_rd,
    output rdata1, rdata2, hazard, issue_fire, pending_any, err
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Decode register file (x0..x31, x0 = 0) with per-register pending-write counters.
// Latency: reads/hazard combinational with writeback bypass; state updates on clk rise.
// Backpressure: hazard blocks issue; writebacks and kills are always accepted.
// Ports: clk, reset (async, active-high), sb (slave side of regfile_scoreboard_if).
module regfile_scoreboard #(
  parameter int PEND_W = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_scoreboard_if.slave  sb
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [31:0]       regs     [32];
  logic [PEND_W-1:0] pend     [32];
  logic [PEND_W-1:0] pend_nxt [32];

  logic              wr_en;
  logic              src1_haz;
  logic              src2_haz;
  logic              dst_haz;
  logic              hazard;
  logic              issue_fire;
  logic              underflow;
  logic              any_pend;
  logic              err_q;

  logic              hit_w;
  logic              hit_k;
  logic [1:0]        dec;
  logic [PEND_W-1:0] base;

  assign wr_en = sb.wen && (sb.wreg != 5'd0);

  // Reads: x0 is constant zero, a same-cycle writeback is forwarded.
  assign sb.rdata1 = (sb.rs1 == 5'd0) ? 32'd0 :
                     (wr_en && sb.wreg == sb.rs1) ? sb.wdata : regs[sb.rs1];
  assign sb.rdata2 = (sb.rs2 == 5'd0) ? 32'd0 :
                     (wr_en && sb.wreg == sb.rs2) ? sb.wdata : regs[sb.rs2];

  // A writeback landing this cycle retires one outstanding write; comparing
  // pend against that retire bit is the same as testing (pend - retire) != 0.
  assign src1_haz = sb.rs1_used && (sb.rs1 != 5'd0) &&
                    (pend[sb.rs1] != PEND_W'(sb.wen && sb.wreg == sb.rs1));
  assign src2_haz = sb.rs2_used && (sb.rs2 != 5'd0) &&
                    (pend[sb.rs2] != PEND_W'(sb.wen && sb.wreg == sb.rs2));

  // Full check uses the registered count only, so a same-cycle retire does not
  // open a slot; this also guarantees pend + inc never wraps.
  assign dst_haz = (sb.issue_rd != 5'd0) && (pend[sb.issue_rd] == PEND_MAX);

  assign hazard     = sb.issue_valid && (src1_haz || src2_haz || dst_haz);
  assign issue_fire = sb.issue_valid && !hazard;

  assign sb.hazard      = hazard;
  assign sb.issue_fire  = issue_fire;
  assign sb.pending_any = any_pend;
  assign sb.err         = err_q;

  always_comb begin
    any_pend = 1'b0;
    for (int r = 1; r < 32; r++) begin
      any_pend = any_pend | (pend[r] != '0);
    end
  end

  // Next counter value: clamp the decrement at zero (flagging underflow), then
  // add the issue increment.
  always_comb begin
    underflow = 1'b0;
    hit_w     = 1'b0;
    hit_k     = 1'b0;
    dec       = 2'd0;
    base      = '0;
    pend_nxt[0] = '0;
    for (int r = 1; r < 32; r++) begin
      hit_w = sb.wen && (sb.wreg == 5'(r));
      hit_k = sb.kill_valid && (sb.kill_rd == 5'(r));
      dec   = {1'b0, hit_w} + {1'b0, hit_k};
      if (dec == 2'd0) begin
        base = pend[r];
      end else if (dec == 2'd1) begin
        if (pend[r] == '0) begin
          base      = '0;
          underflow = 1'b1;
        end else begin
          base = pend[r] - PEND_W'(1);
        end
      end else begin
        if (pend[r] <= PEND_W'(1)) begin
          base      = '0;
          underflow = 1'b1;
        end else begin
          base = pend[r] - PEND_W'(2);
        end
      end
      pend_nxt[r] = base + PEND_W'(issue_fire && (sb.issue_rd == 5'(r)));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 32; r++) begin
        pend[r] <= '0;
      end
    end else begin
      for (int r = 0; r < 32; r++) begin
        pend[r] <= pend_nxt[r];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 32; r++) begin
        regs[r] <= 32'd0;
      end
    end else if (wr_en) begin
      regs[sb.wreg] <= sb.wdata;
    end
  end

  // Sticky until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (underflow) begin
      err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;
  localparam int PW   = 2;
  localparam int MAXP = (1 << PW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_scoreboard_if bus();

  regfile_scoreboard #(.PEND_W(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (bus)
  );

  // Reference model: plain integer counters and a memory image.
  int          pend_m [32];
  logic [31:0] mem_m  [32];
  bit          err_m;
  int          n_cmp;
  int          n_err;

  function automatic logic [31:0] m_rdata(input logic [4:0] rs);
    if (rs == 5'd0) return 32'd0;
    if (bus.wen && bus.wreg == rs) return bus.wdata;
    return mem_m[rs];
  endfunction

  function automatic bit m_src(input logic used, input logic [4:0] rs);
    int eff;
    if (!used || rs == 5'd0) return 1'b0;
    eff = pend_m[rs] - ((bus.wen && bus.wreg == rs) ? 1 : 0);
    return eff != 0;
  endfunction

  function automatic bit m_hazard();
    bit dst;
    if (!bus.issue_valid) return 1'b0;
    dst = (bus.issue_rd != 5'd0) && (pend_m[bus.issue_rd] == MAXP);
    return m_src(bus.rs1_used, bus.rs1) || m_src(bus.rs2_used, bus.rs2) || dst;
  endfunction

  function automatic bit m_pany();
    for (int r = 1; r < 32; r++) if (pend_m[r] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin
      pend_m[r] = 0;
      mem_m[r]  = 32'd0;
    end
    err_m = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic h;
    #1;
    h = m_hazard();
    chk({tag, "_rdata1"}, bus.rdata1, m_rdata(bus.rs1));
    chk({tag, "_rdata2"}, bus.rdata2, m_rdata(bus.rs2));
    chk({tag, "_hazard"}, {31'd0, bus.hazard}, {31'd0, h});
    chk({tag, "_fire"}, {31'd0, bus.issue_fire}, {31'd0, bus.issue_valid && !h});
    chk({tag, "_pany"}, {31'd0, bus.pending_any}, {31'd0, m_pany()});
    chk({tag, "_err"}, {31'd0, bus.err}, {31'd0, err_m});
  endtask

  task automatic tick();
    bit fire;
    int d;
    fire = bus.issue_valid && !m_hazard();
    @(posedge clk);
    for (int r = 1; r < 32; r++) begin
      d = ((bus.wen && bus.wreg == r) ? 1 : 0) + ((bus.kill_valid && bus.kill_rd == r) ? 1 : 0);
      if (pend_m[r] < d) begin
        pend_m[r] = 0;
        err_m     = 1'b1;
      end else begin
        pend_m[r] -= d;
      end
      if (fire && bus.issue_rd == r) pend_m[r]++;
    end
    if (bus.wen && bus.wreg != 5'd0) mem_m[bus.wreg] = bus.wdata;
    #1;
  endtask

  task automatic idle();
    bus.rs1 = 5'd0; bus.rs2 = 5'd0; bus.rs1_used = 1'b0; bus.rs2_used = 1'b0;
    bus.issue_valid = 1'b0; bus.issue_rd = 5'd0;
    bus.wreg = 5'd0; bus.wdata = 32'd0; bus.wen = 1'b0;
    bus.kill_valid = 1'b0; bus.kill_rd = 5'd0;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] v);
    bus.wen = 1'b1; bus.wreg = r; bus.wdata = v;
  endtask

  initial begin
    int q[$];
    n_cmp = 0;
    n_err = 0;
    model_clear();
    idle();
    reset = 1'b1;
    #12 reset = 1'b0;
    @(posedge clk); #1;

    // Reset then idle
    bus.rs1 = 5'd5; bus.rs1_used = 1'b1; bus.issue_valid = 1'b1;
    check_all("rst");
    chk("rst_rdata1_const", bus.rdata1, 32'd0);
    chk("rst_hazard_const", {31'd0, bus.hazard}, 32'd0);
    tick();

    // RAW on x3, resolved by a bypassed writeback
    idle(); bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
    check_all("iss3"); tick();
    idle(); bus.issue_valid = 1'b1; bus.issue_rd = 5'd10; bus.rs1 = 5'd3; bus.rs1_used = 1'b1;
    check_all("raw3_a"); chk("raw3_hazard_const", {31'd0, bus.hazard}, 32'd1); tick();
    check_all("raw3_b"); tick();
    wb(5'd3, 32'hDEADBEEF);
    check_all("byp3");
    chk("byp3_hazard_const", {31'd0, bus.hazard}, 32'd0);
    chk("byp3_rdata_const", bus.rdata1, 32'hDEADBEEF);
    tick();
    idle(); bus.issue_valid = 1'b1; bus.rs1 = 5'd3; bus.rs1_used = 1'b1;
    check_all("arr3"); chk("arr3_rdata_const", bus.rdata1, 32'hDEADBEEF);
    idle(); bus.kill_valid = 1'b1; bus.kill_rd = 5'd10; tick();

    // Destination counter full on x7
    idle(); bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
    for (int i = 0; i < 3; i++) begin check_all("fill7"); tick(); end
    check_all("full7"); chk("full7_fire_const", {31'd0, bus.issue_fire}, 32'd0); tick();
    wb(5'd7, 32'h777);
    check_all("full7_wb"); chk("full7_wb_hazard_const", {31'd0, bus.hazard}, 32'd1); tick();
    bus.wen = 1'b0;
    check_all("refire7"); chk("refire7_fire_const", {31'd0, bus.issue_fire}, 32'd1); tick();
    idle(); wb(5'd7, 32'h7007); bus.kill_valid = 1'b1; bus.kill_rd = 5'd7; tick();
    idle(); wb(5'd7, 32'h7008); check_all("drain7"); tick();

    // Same-cycle issue + writeback, then writeback + kill on x9
    idle(); bus.issue_valid = 1'b1; bus.issue_rd = 5'd9; check_all("iss9"); tick();
    wb(5'd9, 32'h99); check_all("iss9_wb"); tick();
    idle(); bus.issue_valid = 1'b1; bus.rs1 = 5'd9; bus.rs1_used = 1'b1;
    check_all("pend9_one"); chk("pend9_one_hazard_const", {31'd0, bus.hazard}, 32'd1);
    idle(); bus.issue_valid = 1'b1; bus.issue_rd = 5'd9; tick();
    idle(); wb(5'd9, 32'h999); bus.kill_valid = 1'b1; bus.kill_rd = 5'd9;
    check_all("wbkill9"); tick();
    idle(); bus.issue_valid = 1'b1; bus.rs1 = 5'd9; bus.rs1_used = 1'b1;
    check_all("pend9_zero"); chk("pend9_zero_hazard_const", {31'd0, bus.hazard}, 32'd0);

    // x0 write ignored; underflow on x12
    idle(); wb(5'd0, 32'h1234); check_all("x0wr"); tick();
    idle(); check_all("x0rd");
    wb(5'd12, 32'hCAFEF00D); tick();
    idle(); bus.rs1 = 5'd12; bus.rs1_used = 1'b1; bus.issue_valid = 1'b1;
    check_all("uf12"); chk("uf12_err_const", {31'd0, bus.err}, 32'd1);

    // Asynchronous reset mid-operation
    idle(); wb(5'd4, 32'h44444444); tick();
    idle(); bus.issue_valid = 1'b1; bus.issue_rd = 5'd4; tick();
    idle(); bus.rs1 = 5'd4; check_all("pre_rst");
    #3 reset = 1'b1;
    model_clear();
    check_all("async_rst");
    chk("async_rst_pany_const", {31'd0, bus.pending_any}, 32'd0);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    check_all("post_rst"); chk("post_rst_x4_const", bus.rdata1, 32'd0);

    // Randomised traffic on x0..x7
    for (int c = 0; c < 400; c++) begin
      idle();
      bus.rs1 = 5'($urandom_range(0, 7));  bus.rs1_used = 1'($urandom);
      bus.rs2 = 5'($urandom_range(0, 7));  bus.rs2_used = 1'($urandom);
      bus.issue_valid = 1'($urandom);      bus.issue_rd = 5'($urandom_range(0, 7));
      q.delete();
      for (int r = 1; r < 8; r++) if (pend_m[r] > 0) q.push_back(r);
      if (q.size() > 0 && $urandom_range(0, 1) == 1)
        wb(5'(q[$urandom_range(0, q.size() - 1)]), $urandom);
      else if ($urandom_range(0, 15) == 0)
        wb(5'($urandom_range(0, 7)), $urandom);
      if (q.size() > 0 && $urandom_range(0, 7) == 0) begin
        bus.kill_valid = 1'b1;
        bus.kill_rd = 5'(q[$urandom_range(0, q.size() - 1)]);
      end
      check_all("rnd");
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Decode-stage register file plus scoreboard that terminates the writeback port (`wreg`/`wdata`/`wen`) driven by the write stage. It holds x0–x31 with x0 hard-wired to zero and provides two bypassed read ports. A per-register pending-write counter tracks instructions issued but not yet written back or squashed. From these counters it raises `hazard` so decode holds an instruction whose sources are not yet available, or whose destination counter would overflow.

## Interface
- `PEND_W`, default 2: pending-counter width per register. Maximum outstanding writes per register is 2^PEND_W−1.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears every register, counter and flag.
- `rs1`, `rs2`  in  5 each  source register indices of the instruction in decode.
- `rs1_used`, `rs2_used`  in  1 each  the instruction reads that source.
- `rdata1`, `rdata2`  out  32 each  source values, combinational.
- `issue_valid`  in  1  decode wants to issue its instruction this cycle.
- `issue_rd`  in  5  destination of the issuing instruction; 0 means no write.
- `hazard`  out  1  combinational; issue is blocked this cycle.
- `issue_fire`  out  1  `issue_valid && !hazard`.
- `wreg`  in  5  writeback destination, from the write stage.
- `wdata`  in  32  writeback data.
- `wen`  in  1  writeback valid.
- `kill_valid`  in  1  an issued instruction was squashed and will never write back.
- `kill_rd`  in  5  destination of the squashed instruction.
- `pending_any`  out  1  any counter is nonzero.
- `err`  out  1  sticky; a counter underflow was attempted.

## Operation
- Array: 32×32. A write occurs when `wen && wreg!=0`. x0 reads 0 and is never written. Writes to x0 are ignored and do not touch any counter.
- Read bypass: if `wen && wreg!=0 && wreg==rsN`, `rdataN=wdata`; otherwise the array value. For `rsN==0`, `rdataN=0`.
- Counters `pend[1..31]`, each `PEND_W` bits. Next value = pend + inc − dec, where:
  - inc = `issue_fire && issue_rd==r`
  - dec = (`wen && wreg==r`) + (`kill_valid && kill_rd==r`)
  - Both decrement sources may hit the same r in one cycle (dec=2).
- Underflow: if pend − dec would be < 0 (before adding inc), the counter clamps at 0 and `err` sets next cycle. `err` stays set until reset.
- Source hazard for source N: `rsN_used && rsN!=0 && pendEff(rsN)!=0`.
  - pendEff = pend − (`wen && wreg==rsN` ? 1 : 0). A writeback landing this cycle retires one pending write, and its data is supplied through the bypass.
- Destination hazard: `issue_rd!=0 && pend[issue_rd]==2^PEND_W−1`. A same-cycle writeback or kill to that register does not relieve it, which keeps the full check a pure counter compare.
- `hazard` = (src1 hazard | src2 hazard | dest hazard) && `issue_valid`. It is 0 when `issue_valid` is 0.
- `pending_any` is the OR of registered counters and reflects state after the last edge.

## Timing
- Reset values: array all 0, every counter 0, `err`=0, `pending_any`=0.
  - `hazard`, `issue_fire`, `rdata1` and `rdata2` are combinational. With idle inputs under reset they read 0.
- Reset asserted mid-operation: all state clears immediately. Writebacks or kills for pre-reset issues that arrive after reset are underflows and set `err`. The pipeline must be flushed alongside reset.
- Write latency: data written at edge T is readable from the array after T. In the T−1 cycle it is already visible through the bypass.
- Counter update is visible in `hazard` on the cycle after the edge.
  - Issue-to-hazard: an instruction fired at edge T makes a dependent instruction see `hazard`=1 in cycle T+1.
- Simultaneous issue and writeback to the same rd: the count is unchanged.
- No stall back toward writeback: a writeback is always accepted.

## Test plan
- Reset then idle:
  - `rs1`=5, `rs1_used`=1, `issue_valid`=1 → `rdata1`=0, `hazard`=0, `pending_any`=0, `err`=0.
- Issue `issue_rd`=3, next cycle issue an instruction with `rs1`=3:
  - `hazard`=1 until a cycle with `wen`=1, `wreg`=3, `wdata`=0xDEADBEEF.
  - In that cycle `hazard`=0 and `rdata1`=0xDEADBEEF (bypass).
  - The following cycle `pend[3]`=0 and the array holds 0xDEADBEEF.
- Issue rd=7 three times (PEND_W=2):
  - The fourth `issue_valid` with rd=7 → `hazard`=1, `issue_fire`=0.
  - After one `wen` to x7, the next cycle's fourth issue fires.
- Same cycle: `issue_fire` rd=9 and `wen` wreg=9 with pend[9]=1 → pend[9] stays 1.
  - Then same cycle `wen` wreg=9 and `kill_valid` kill_rd=9 with pend[9]=2 → pend[9]=0.
- `wen`=1, `wreg`=0, `wdata`=0x1234 → x0 still reads 0 and no counter changes.
  - Then `wen` wreg=12 with pend[12]=0 → `err`=1 next cycle, x12=wdata, pend[12]=0.
- Issue rd=4, then assert `reset` asynchronously between edges:
  - `pending_any`, counters and `err` drop to 0 immediately. x4 reads 0 afterwards.
